// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: sequences one RV32 core instruction at a time over a single
// single-port memory. The sequence is an optional data access, then the
// next-instruction fetch. The core is held on stall and released for exactly
// one cycle with both results registered. A host port (load/debug) is served
// only between instructions.
// Ports:
//   clk, rstn                        clock, async active-low reset
//   instr_addr                       core fetch address
//   data_addr/_wen/_be/_wdata        core data access (be==0: no access)
//   instruction, data_rdata, stall   results and hold to the core
//   host_req/_we/_addr/_be/_wdata    host request (stable until host_gnt)
//   host_gnt, host_rvalid, host_rdata host accept pulse / response
//   mem_req/_we/_addr/_be/_wdata     memory request (held until mem_gnt)
//   mem_gnt, mem_rvalid, mem_rdata   memory accept / response
module core_mem_arbiter #(
  parameter bit HOST_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] instr_addr,
  input  logic [31:0] data_addr,
  input  logic        data_wen,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_wdata,
  output logic [31:0] instruction,
  output logic [31:0] data_rdata,
  output logic        stall,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [3:0]  host_be,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  typedef enum logic [2:0] {
    ARB, H_REQ, H_WAIT, D_REQ, D_WAIT, I_REQ, I_WAIT, REL
  } state_t;

  state_t state, state_nx;
  logic   host_sel;
  logic   enter_h, enter_d, enter_i;

  assign host_sel = HOST_EN && host_req;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ARB;
    else       state <= state_nx;
  end

  // Next-state logic and request-entry strobes.
  always_comb begin
    state_nx = state;
    enter_h  = 1'b0;
    enter_d  = 1'b0;
    enter_i  = 1'b0;
    case (state)
      ARB: begin
        if (host_sel)              state_nx = H_REQ;
        else if (data_be != 4'h0)  state_nx = D_REQ;
        else                       state_nx = I_REQ;
      end
      H_REQ:  if (mem_gnt)    state_nx = H_WAIT;
      H_WAIT: if (mem_rvalid) state_nx = ARB;
      D_REQ:  if (mem_gnt)    state_nx = D_WAIT;
      D_WAIT: if (mem_rvalid) state_nx = I_REQ;
      I_REQ:  if (mem_gnt)    state_nx = I_WAIT;
      I_WAIT: if (mem_rvalid) state_nx = REL;
      REL:                    state_nx = ARB;
      default:                state_nx = ARB;
    endcase
    enter_h = (state_nx == H_REQ) && (state != H_REQ);
    enter_d = (state_nx == D_REQ) && (state != D_REQ);
    enter_i = (state_nx == I_REQ) && (state != I_REQ);
  end

  // Host accept must coincide with the memory accept it forwards.
  assign host_gnt = HOST_EN && (state == H_REQ) && mem_gnt;

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall       <= 1'b1;
      instruction <= DW'(0);
      data_rdata  <= DW'(0);
      host_rdata  <= DW'(0);
      host_rvalid <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= AW'(0);
      mem_be      <= BW'(0);
      mem_wdata   <= DW'(0);
    end else begin
      stall       <= (state_nx != REL);
      mem_req     <= (state_nx == H_REQ) || (state_nx == D_REQ) || (state_nx == I_REQ);
      host_rvalid <= 1'b0;
      // Attributes are latched once on entry and held for the whole request.
      if (enter_h) begin
        mem_we    <= host_we;
        mem_addr  <= host_addr;
        mem_be    <= host_be;
        mem_wdata <= host_wdata;
      end else if (enter_d) begin
        mem_we    <= data_wen;
        mem_addr  <= data_addr;
        mem_be    <= data_be;
        mem_wdata <= data_wdata;
      end else if (enter_i) begin
        mem_we    <= 1'b0;
        mem_addr  <= instr_addr;
        mem_be    <= BW'(4'hF);
        mem_wdata <= DW'(0);
      end
      // Responses are only meaningful in a wait state; mem_we still holds the
      // data access direction during D_WAIT.
      if (mem_rvalid) begin
        case (state)
          H_WAIT: begin
            host_rvalid <= 1'b1;
            host_rdata  <= mem_rdata;
          end
          D_WAIT: if (!mem_we) data_rdata <= mem_rdata;
          I_WAIT: instruction <= mem_rdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed + randomized bench for core_mem_arbiter with a
// wait-state-configurable memory responder and a word-array reference model.
module tb_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] instr_addr, data_addr, data_wdata;
  logic        data_wen;
  logic [3:0]  data_be;
  logic [31:0] instruction, data_rdata;
  logic        stall;
  logic        host_req, host_we;
  logic [31:0] host_addr, host_wdata;
  logic [3:0]  host_be;
  logic        host_gnt, host_rvalid;
  logic [31:0] host_rdata;
  logic        mem_req, mem_we, mem_gnt;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  // HOST_EN=0 instance, with its own trivial memory
  logic [31:0] n_instruction, n_data_rdata, n_host_rdata, n_mem_addr, n_mem_wdata;
  logic        n_stall, n_host_gnt, n_host_rvalid, n_mem_req, n_mem_we, n_mem_gnt;
  logic [3:0]  n_mem_be;
  logic        n_mem_rvalid = 1'b0;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  core_mem_arbiter #(.HOST_EN(1'b1)) dut (
    .clk(clk), .rstn(rstn),
    .instr_addr(instr_addr), .data_addr(data_addr), .data_wen(data_wen),
    .data_be(data_be), .data_wdata(data_wdata),
    .instruction(instruction), .data_rdata(data_rdata), .stall(stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_be(host_be), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  core_mem_arbiter #(.HOST_EN(1'b0)) u_nohost (
    .clk(clk), .rstn(rstn),
    .instr_addr(32'h0), .data_addr(32'h0), .data_wen(1'b0),
    .data_be(4'h0), .data_wdata(32'h0),
    .instruction(n_instruction), .data_rdata(n_data_rdata), .stall(n_stall),
    .host_req(1'b1), .host_we(1'b1), .host_addr(32'h40),
    .host_be(4'hF), .host_wdata(32'hCAFE0000),
    .host_gnt(n_host_gnt), .host_rvalid(n_host_rvalid), .host_rdata(n_host_rdata),
    .mem_req(n_mem_req), .mem_we(n_mem_we), .mem_addr(n_mem_addr), .mem_be(n_mem_be),
    .mem_wdata(n_mem_wdata), .mem_gnt(n_mem_gnt), .mem_rvalid(n_mem_rvalid),
    .mem_rdata(32'h00000013)
  );

  assign n_mem_gnt = n_mem_req;
  always @(posedge clk) n_mem_rvalid <= n_mem_req && n_mem_gnt;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memory responder: grant after gnt_delay waiting cycles, response rv_delay
  // cycles after the grant cycle. Not affected by rstn (late responses survive).
  logic [31:0] mem_arr [256];
  int unsigned gnt_delay = 0, rv_delay = 1, wcnt = 0, rcnt = 0;
  logic        pend = 1'b0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'h0;
  logic [31:0] pl_data = 32'h0;

  assign mem_gnt = mem_req && (wcnt >= gnt_delay);

  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (pl_en) mem_arr[pl_idx] <= pl_data;
    if (mem_req && !mem_gnt) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
    if (mem_req && mem_gnt) begin
      mem_rdata <= mem_arr[mem_addr[9:2]];
      if (mem_we) mem_arr[mem_addr[9:2]] <= merge(mem_arr[mem_addr[9:2]], mem_wdata, mem_be);
      if (rv_delay <= 1) mem_rvalid <= 1'b1;
      else begin
        pend <= 1'b1;
        rcnt <= rv_delay - 1;
      end
    end else if (pend) begin
      if (rcnt <= 1) begin
        mem_rvalid <= 1'b1;
        pend       <= 1'b0;
      end
      rcnt <= rcnt - 1;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [256];
  logic [31:0] exp_drd = 32'h0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One core instruction; entered and left at the negedge of an ARB cycle.
  task automatic run_instr(input logic [31:0] ia, input logic [31:0] da, input logic wen,
                           input logic [3:0] be, input logic [31:0] wd,
                           input int unsigned gd, input int unsigned rd, input int host_at);
    logic [31:0] exp_i;
    logic [68:0] seen[$];
    logic [68:0] p_attr, cur;
    logic        p_req, p_gnt;
    int          n_acc, c;
    bit          rel;
    instr_addr = ia; data_addr = da; data_wen = wen; data_be = be; data_wdata = wd;
    gnt_delay = gd; rv_delay = rd;
    n_acc = (be != 4'h0) ? 2 : 1;
    if (be != 4'h0) begin
      if (wen) ref_mem[da[9:2]] = merge(ref_mem[da[9:2]], wd, be);
      else     exp_drd = ref_mem[da[9:2]];
    end
    exp_i = ref_mem[ia[9:2]];
    c = 1; rel = 0; p_req = 0; p_gnt = 0; p_attr = '0;
    for (int k = 0; k < 300 && !rel; k++) begin
      if (c == host_at) host_req = 1'b1;
      chk("host_gnt_during_core", 72'(host_gnt), 72'(0));
      cur = {mem_we, mem_be, mem_addr, mem_wdata};
      if (mem_req && p_req && !p_gnt) chk("mem_attr_stable", 72'(cur), 72'(p_attr));
      if (mem_req && mem_gnt) seen.push_back(cur);
      p_req = mem_req; p_gnt = mem_gnt; p_attr = cur;
      if (!stall) rel = 1;
      else begin
        @(posedge clk); @(negedge clk); c++;
      end
    end
    chk("rel_reached", 72'(rel), 72'(1));
    chk("cycles", 72'(c), 72'(2 + n_acc * (gd + 1 + rd)));
    chk("instruction", 72'(instruction), 72'(exp_i));
    chk("data_rdata", 72'(data_rdata), 72'(exp_drd));
    chk("n_mem_accesses", 72'(seen.size()), 72'(n_acc));
    if (seen.size() == n_acc) begin
      if (n_acc == 2) chk("data_req_attr", 72'(seen[0]), 72'({wen, be, da, wd}));
      chk("fetch_req_attr", 72'(seen[n_acc-1]), 72'({1'b0, 4'hF, ia, 32'h0}));
    end
    @(posedge clk); @(negedge clk);
    chk("single_rel", 72'(stall), 72'(1));
    chk("instr_held", 72'(instruction), 72'(exp_i));
    chk("host_gnt_arb", 72'(host_gnt), 72'(0));
  endtask

  // One host transaction; entered at an ARB negedge, left at the response cycle.
  task automatic host_op(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd);
    logic [31:0] exp_r;
    int c;
    bit got;
    host_req = 1'b1; host_we = we; host_addr = a; host_be = be; host_wdata = wd;
    exp_r = ref_mem[a[9:2]];
    if (we) ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], wd, be);
    c = 1; got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      if (host_gnt) got = 1;
      else begin
        @(posedge clk); @(negedge clk); c++;
      end
    end
    chk("host_gnt_seen", 72'(got), 72'(1));
    if (gnt_delay == 0) chk("host_gnt_latency", 72'(c), 72'(2));
    chk("host_req_attr", 72'({mem_we, mem_be, mem_addr, mem_wdata}), 72'({we, be, a, wd}));
    @(posedge clk); @(negedge clk);
    host_req = 1'b0;
    got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      if (host_rvalid) got = 1;
      else begin
        @(posedge clk); @(negedge clk);
      end
    end
    chk("host_rvalid_seen", 72'(got), 72'(1));
    if (!we) chk("host_rdata", 72'(host_rdata), 72'(exp_r));
  endtask

  initial begin
    logic [31:0] v, ia, da, wd;
    logic [3:0]  be;
    int          op, nrel;
    rstn = 1'b0;
    instr_addr = 0; data_addr = 0; data_wen = 0; data_be = 0; data_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_be = 0; host_wdata = 0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_stall", 72'(stall), 72'(1));
    chk("rst_instruction", 72'(instruction), 72'(0));
    chk("rst_data_rdata", 72'(data_rdata), 72'(0));
    chk("rst_host_rdata", 72'(host_rdata), 72'(0));
    chk("rst_mem_req", 72'(mem_req), 72'(0));
    chk("rst_mem_attr", 72'({mem_we, mem_be, mem_addr, mem_wdata}), 72'(0));
    chk("rst_host_gnt", 72'(host_gnt), 72'(0));
    chk("rst_host_rvalid", 72'(host_rvalid), 72'(0));

    // Preload memory and reference image while in reset
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      if (i == 0)  v = 32'h00500093;
      if (i == 64) v = 32'hDEADBEEF;
      pl_en = 1'b1; pl_idx = 8'(i); pl_data = v; ref_mem[i] = v;
      @(negedge clk);
    end
    pl_en = 1'b0;
    rstn = 1'b1;

    // First fetch from 0, load, store-then-fetch, wait states
    run_instr(32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 0, 1, 0);
    run_instr(32'h4, 32'h100, 1'b0, 4'hF, 32'h0, 0, 1, 0);
    run_instr(32'h8, 32'h8, 1'b1, 4'hF, 32'h00000013, 0, 1, 0);
    run_instr(32'hC, 32'h100, 1'b0, 4'hF, 32'h0, 3, 2, 0);

    // Host write raised mid-fetch waits for the next ARB; then read it back
    host_we = 1'b1; host_addr = 32'h40; host_be = 4'hF; host_wdata = 32'h12345678;
    run_instr(32'h10, 32'h0, 1'b0, 4'h0, 32'h0, 1, 1, 2);
    gnt_delay = 0; rv_delay = 1;
    host_op(1'b1, 32'h40, 4'hF, 32'h12345678);
    host_op(1'b0, 32'h40, 4'hF, 32'h0);
    run_instr(32'h40, 32'h0, 1'b0, 4'h0, 32'h0, 0, 1, 0);

    // Reset pulse during D_WAIT; the late response must be discarded
    instr_addr = 32'h14; data_addr = 32'h100; data_wen = 1'b0; data_be = 4'hF;
    gnt_delay = 0; rv_delay = 5;
    @(posedge clk); @(negedge clk);
    chk("rst_test_dreq", 72'({mem_req, mem_addr}), 72'({1'b1, 32'h100}));
    @(posedge clk); @(negedge clk);
    chk("rst_test_dwait_stall", 72'(stall), 72'(1));
    rstn = 1'b0;
    #1;
    chk("rst_async_mem_req", 72'(mem_req), 72'(0));
    chk("rst_async_stall", 72'(stall), 72'(1));
    chk("rst_async_data_rdata", 72'(data_rdata), 72'(0));
    chk("rst_async_instruction", 72'(instruction), 72'(0));
    @(posedge clk); @(negedge clk);
    rstn = 1'b1;
    exp_drd = 32'h0;
    run_instr(32'h14, 32'h0, 1'b0, 4'h0, 32'h0, 6, 1, 0);

    // Randomized instruction stream with occasional host transactions
    for (int n = 0; n < 40; n++) begin
      ia = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      da = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      wd = $urandom;
      op = $urandom_range(0, 2);
      be = (op == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      run_instr(ia, da, op == 2, be, wd, $urandom_range(0, 2), $urandom_range(1, 3), 0);
      if (n % 8 == 7) begin
        gnt_delay = $urandom_range(0, 2); rv_delay = $urandom_range(1, 3);
        host_op(1'($urandom_range(0, 1)), {22'h0, 8'($urandom_range(0, 255)), 2'b00},
                4'($urandom_range(1, 15)), $urandom);
      end
    end

    // HOST_EN=0 instance: host never served, core keeps running
    nrel = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("nohost_gnt", 72'(n_host_gnt), 72'(0));
      chk("nohost_rvalid", 72'(n_host_rvalid), 72'(0));
      if (!n_stall) nrel++;
    end
    chk("nohost_core_runs", 72'(nrel > 0), 72'(1));
    chk("nohost_instruction", 72'(n_instruction), 72'(32'h00000013));

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Sequencer and arbiter that lets the single-cycle RV32 core share one single-port memory between instruction fetch, core data access and an external host port (program load/debug). For each core instruction it performs the data access (if any), then the next-instruction fetch, holding `stall` high throughout and releasing the core for exactly one cycle with both results presented on registered buses. Sits between `core` and the memory/interconnect.

## Interface
- `HOST_EN`, default 1: 1 = host port active; 0 = `host_req` ignored, `host_gnt`/`host_rvalid` tied 0.
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `instr_addr` in 32: core fetch address.
- `data_addr` in 32: core data address.
- `data_wen` in 1: core data write enable.
- `data_be` in 4: core byte enables; `4'b0000` = no data access this instruction.
- `data_wdata` in 32: core store data.
- `instruction` out 32: fetched instruction to core.
- `data_rdata` out 32: load data to core.
- `stall` out 1: core hold.
- `host_req` in 1: host request, attributes stable until `host_gnt`.
- `host_we` in 1: host write.
- `host_addr` in 32: host address.
- `host_be` in 4: host byte enables.
- `host_wdata` in 32: host write data.
- `host_gnt` out 1: host request accepted (pulse).
- `host_rvalid` out 1: host response (pulse); `host_rdata` valid.
- `host_rdata` out 32: host read data.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_be` out 4, `mem_wdata` out 32: memory request; held stable until `mem_gnt`.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1: response (reads and writes), earliest the cycle after `mem_gnt`.
- `mem_rdata` in 32: read data, valid with `mem_rvalid`.

## Operation
- States: ARB, H_REQ, H_WAIT, D_REQ, D_WAIT, I_REQ, I_WAIT, REL. At most one memory transaction outstanding.
- ARB: no request issued. If `HOST_EN && host_req` -> H_REQ (host priority, boot/load use); else if `data_be != 0` -> D_REQ; else -> I_REQ.
- x_REQ: `mem_req=1`; attributes driven from registers captured on entry (host: host_*; data: data_addr/data_wen/data_be/data_wdata; fetch: instr_addr, we=0, be=4'b1111, wdata=0). Stay until `mem_gnt`, then -> x_WAIT. H_REQ drives `host_gnt=1` in the `mem_gnt` cycle.
- x_WAIT: `mem_req=0`; on `mem_rvalid`: H_WAIT -> `host_rvalid=1`, `host_rdata<=mem_rdata`, -> ARB; D_WAIT -> `data_rdata<=mem_rdata` if read (unchanged on write), -> I_REQ; I_WAIT -> `instruction<=mem_rdata`, -> REL.
- REL: `stall=0` for exactly this cycle; core commits on the following edge. -> ARB.
- Data access precedes fetch, so a store to the next instruction's address is fetched with new contents.
- `stall=1` in every state except REL. Host transactions occur only between instructions, never between a core data access and its fetch.
- `mem_rvalid` outside an x_WAIT state is ignored; `mem_gnt` outside x_REQ ignored.

## Timing
- Reset values: state ARB, `stall=1`, `instruction=0`, `data_rdata=0`, `host_rdata=0`, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_be=0`, `mem_wdata=0`, `host_gnt=0`, `host_rvalid=0`.
- Zero-wait memory (gnt same cycle as req, rvalid next cycle): no-data instruction = 4 cycles (ARB, I_REQ, I_WAIT, REL); load/store = 6 cycles. Host transaction = 3 cycles (ARB, H_REQ, H_WAIT).
- `instruction`/`data_rdata` registered; stable through REL and until next capture.
- `host_req` raised during a core sequence waits until next ARB.
- `rstn` asserted mid-transaction: immediate return to ARB, `mem_req` drops asynchronously, captured response discarded; core fetch restarts from ARB after release.
- Back-to-back host requests starve the core by design; no fairness counter.

## Test plan
- Reset, no host, memory zero-wait, mem[0]=0x00500093: `stall=1` until REL at cycle 4 after reset release, `instruction=0x00500093` in REL, `mem_addr=0` during I_REQ.
- Load: `data_be=4'b1111`, `data_wen=0`, `data_addr=0x100`, mem[0x100]=0xDEADBEEF -> D_REQ addr 0x100 then I_REQ, `data_rdata=0xDEADBEEF` in REL, 6-cycle period.
- Store to 0x8 then fetch 0x8: store wdata 0x00000013 -> following fetch returns 0x00000013.
- Wait states: `mem_gnt` delayed 3 cycles, `mem_rvalid` 2 cycles after gnt -> `mem_req` attributes stable throughout, `stall` high until REL, single REL pulse.
- Host write 0x12345678 to 0x40 while core mid-fetch -> `host_gnt` only after REL+ARB; subsequent host read of 0x40 -> `host_rvalid` with `host_rdata=0x12345678`; with `HOST_EN=0` `host_gnt` never asserts.
- `rstn` pulsed during D_WAIT -> `mem_req=0`, state ARB, late `mem_rvalid` ignored, `data_rdata=0`, next REL occurs normally.
